// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters,
// with registered per-port responses and the architectural NZCV register.
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [CTRL_W-1:0] req0_ctrl,
   input  logic              req0_setflags,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [CTRL_W-1:0] req1_ctrl,
   input  logic              req1_setflags,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [3:0]        alu_flags,
   output logic              rsp0_valid,
   input  logic              rsp0_ready,
   output logic [DATA_W-1:0] rsp0_result,
   output logic [3:0]        rsp0_flags,
   output logic              rsp1_valid,
   input  logic              rsp1_ready,
   output logic [DATA_W-1:0] rsp1_result,
   output logic [3:0]        rsp1_flags,
   output logic [3:0]        flags_q
);
   logic              elig0, elig1, gnt0, gnt1, sel_sf, logic_op;
   logic [3:0]        cap_flags, flags_d;
   logic              last_q, last_d;
   logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
   logic [DATA_W-1:0] rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
   logic [3:0]        rsp0_flags_q, rsp0_flags_d, rsp1_flags_q, rsp1_flags_d;
   // last_q=1 means port 1 was granted last, so port 0 wins the next contention
   always_comb begin
      elig0     = req0_valid & (~rsp0_valid_q | rsp0_ready);
      elig1     = req1_valid & (~rsp1_valid_q | rsp1_ready);
      gnt0      = reset_n & elig0 & (~elig1 | last_q);
      gnt1      = reset_n & elig1 & (~elig0 | ~last_q);
      alu_a     = gnt0 ? req0_a : gnt1 ? req1_a : '0;
      alu_b     = gnt0 ? req0_b : gnt1 ? req1_b : '0;
      alu_ctrl  = gnt0 ? req0_ctrl : gnt1 ? req1_ctrl : '0;
      sel_sf    = (gnt0 & req0_setflags) | (gnt1 & req1_setflags);
      logic_op  = alu_ctrl[CTRL_W-1:1] == '0;
      cap_flags = logic_op ? {alu_flags[3:2], flags_q[1:0]} : alu_flags;
      flags_d   = sel_sf ? cap_flags : flags_q;
      last_d    = gnt1 ? 1'b1 : gnt0 ? 1'b0 : last_q;
      rsp0_valid_d  = gnt0 | (rsp0_valid_q & ~rsp0_ready);
      rsp0_result_d = gnt0 ? alu_result : rsp0_result_q;
      rsp0_flags_d  = gnt0 ? cap_flags : rsp0_flags_q;
      rsp1_valid_d  = gnt1 | (rsp1_valid_q & ~rsp1_ready);
      rsp1_result_d = gnt1 ? alu_result : rsp1_result_q;
      rsp1_flags_d  = gnt1 ? cap_flags : rsp1_flags_q;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q       <= 4'b0000;
         last_q        <= 1'b1;
         rsp0_valid_q  <= 1'b0;
         rsp0_result_q <= '0;
         rsp0_flags_q  <= 4'b0000;
         rsp1_valid_q  <= 1'b0;
         rsp1_result_q <= '0;
         rsp1_flags_q  <= 4'b0000;
      end else begin
         flags_q       <= flags_d;
         last_q        <= last_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp0_flags_q  <= rsp0_flags_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp1_result_q <= rsp1_result_d;
         rsp1_flags_q  <= rsp1_flags_d;
      end
   end
   assign req0_ready  = gnt0;
   assign req1_ready  = gnt1;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp0_flags  = rsp0_flags_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp1_result = rsp1_result_q;
   assign rsp1_flags  = rsp1_flags_q;
endmodule
